// File: rtl/bratcr_ctrl.sv
`default_nettype none
// =============================================================================
// Module : bratcr_ctrl
// Branch checkpoint FIFO allocator with mispredict restore/drain sequencing.
// Rev    : 1.0
// =============================================================================
module bratcr_ctrl #(
  parameter int BRATCR_NUM_ETY      = 4,
  parameter int BRATCR_NUM_ETY_CLOG = 2,
  parameter int ROB_SIZE_CLOG       = 5,
  parameter int ISSUE_WIDTH_MAX     = 2
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [ISSUE_WIDTH_MAX-1:0]                     br_req_id,
  input  logic [ROB_SIZE_CLOG-1:0]                       rob_is_ptr,
  output logic [ISSUE_WIDTH_MAX-1:0]                     ckpt_wr_en,
  output logic [ISSUE_WIDTH_MAX*BRATCR_NUM_ETY_CLOG-1:0] ckpt_wr_idx,
  output logic                                           rename_stall,
  input  logic                                           br_mispredict,
  input  logic [ROB_SIZE_CLOG-1:0]                       br_resolve_robid,
  input  logic [ISSUE_WIDTH_MAX-1:0]                     br_ret,
  input  logic                                           rob_flush_done,
  output logic                                           restore_en,
  output logic [BRATCR_NUM_ETY_CLOG-1:0]                 restore_idx,
  output logic                                           flush_fe,
  output logic [BRATCR_NUM_ETY_CLOG:0]                   ckpt_free_cnt,
  output logic                                           err_sticky
);

  localparam int CW = BRATCR_NUM_ETY_CLOG + 1;
  localparam logic [CW-1:0] C_NUM_ETY = CW'(BRATCR_NUM_ETY);

  typedef logic [BRATCR_NUM_ETY_CLOG-1:0] idx_t;
  typedef logic [CW-1:0]                  cnt_t;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESTORE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  idx_t                      head_q, head_d;
  idx_t                      tail_q, tail_d;
  cnt_t                      occ_q, occ_d;
  logic [BRATCR_NUM_ETY-1:0] valid_q, valid_d;
  logic [ROB_SIZE_CLOG-1:0]  robid_q [BRATCR_NUM_ETY];
  logic [ROB_SIZE_CLOG-1:0]  robid_d [BRATCR_NUM_ETY];
  logic                      restore_en_q, restore_en_d;
  idx_t                      restore_idx_q, restore_idx_d;
  logic                      flush_fe_q, flush_fe_d;
  logic                      err_sticky_q, err_sticky_d;

  cnt_t req_cnt, ret_cnt, freed, alloc_cnt, kept, free_cnt;
  logic alloc_ok, cam_hit;
  idx_t cam_idx, slot_off;

  always_comb begin
    req_cnt = '0;
    ret_cnt = '0;
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      req_cnt = req_cnt + cnt_t'(br_req_id[i]);
      ret_cnt = ret_cnt + cnt_t'(br_ret[i]);
    end
  end

  assign free_cnt     = C_NUM_ETY - occ_q;
  assign rename_stall = (state_q != S_IDLE) || (free_cnt < req_cnt);
  // A mispredict owns the cycle: the group is dropped, not partially written.
  assign alloc_ok     = (state_q == S_IDLE) && !rename_stall && !br_mispredict;
  assign alloc_cnt    = alloc_ok ? req_cnt : '0;
  assign freed        = (ret_cnt > occ_q) ? occ_q : ret_cnt;

  always_comb begin
    cam_hit = 1'b0;
    cam_idx = '0;
    for (int e = 0; e < BRATCR_NUM_ETY; e++) begin
      if (!cam_hit && valid_q[e] && (robid_q[e] == br_resolve_robid)) begin
        cam_hit = 1'b1;
        cam_idx = idx_t'(e);
      end
    end
  end

  always_comb begin
    slot_off    = '0;
    ckpt_wr_en  = '0;
    ckpt_wr_idx = '0;
    robid_d     = robid_q;
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      ckpt_wr_en[i] = alloc_ok & br_req_id[i];
      ckpt_wr_idx[i*BRATCR_NUM_ETY_CLOG +: BRATCR_NUM_ETY_CLOG] = tail_q + slot_off;
      if (ckpt_wr_en[i]) begin
        robid_d[tail_q + slot_off] = rob_is_ptr + ROB_SIZE_CLOG'(i);
      end
      if (br_req_id[i]) begin
        slot_off = slot_off + 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    head_d        = head_q + idx_t'(freed);
    tail_d        = tail_q + idx_t'(alloc_cnt);
    occ_d         = occ_q - freed + alloc_cnt;
    restore_idx_d = restore_idx_q;
    err_sticky_d  = err_sticky_q | (ret_cnt > occ_q);
    kept          = '0;
    case (state_q)
      S_IDLE: begin
        if (br_mispredict) begin
          if (cam_hit) begin
            // Entries older than k survive; a retire that reaches past k empties the FIFO.
            kept = cnt_t'(cam_idx - head_q);
            if (freed <= kept) begin
              occ_d = kept - freed;
            end else begin
              occ_d  = '0;
              head_d = cam_idx;
            end
            tail_d        = cam_idx;
            restore_idx_d = cam_idx;
            state_d       = S_RESTORE;
          end else begin
            err_sticky_d = 1'b1;
          end
        end
      end
      S_RESTORE: state_d = S_DRAIN;
      S_DRAIN:   if (rob_flush_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    for (int e = 0; e < BRATCR_NUM_ETY; e++) begin
      valid_d[e] = cnt_t'(idx_t'(e) - head_d) < occ_d;
    end
    restore_en_d = (state_d == S_RESTORE);
    flush_fe_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      occ_q         <= '0;
      valid_q       <= '0;
      for (int e = 0; e < BRATCR_NUM_ETY; e++) robid_q[e] <= '0;
      restore_en_q  <= 1'b0;
      restore_idx_q <= '0;
      flush_fe_q    <= 1'b0;
      err_sticky_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      occ_q         <= occ_d;
      valid_q       <= valid_d;
      robid_q       <= robid_d;
      restore_en_q  <= restore_en_d;
      restore_idx_q <= restore_idx_d;
      flush_fe_q    <= flush_fe_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  assign restore_en    = restore_en_q;
  assign restore_idx   = restore_idx_q;
  assign flush_fe      = flush_fe_q;
  assign ckpt_free_cnt = free_cnt;
  assign err_sticky    = err_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_bratcr_ctrl.sv
`default_nettype none
// Bench for bratcr_ctrl: vector table with same-cycle checks and a queue of post-edge expectations.
module tb_bratcr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_req_id;
  logic [4:0] rob_is_ptr;
  logic [1:0] ckpt_wr_en;
  logic [3:0] ckpt_wr_idx;
  logic       rename_stall;
  logic       br_mispredict;
  logic [4:0] br_resolve_robid;
  logic [1:0] br_ret;
  logic       rob_flush_done;
  logic       restore_en;
  logic [1:0] restore_idx;
  logic       flush_fe;
  logic [2:0] ckpt_free_cnt;
  logic       err_sticky;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bratcr_ctrl #(
    .BRATCR_NUM_ETY      (4),
    .BRATCR_NUM_ETY_CLOG (2),
    .ROB_SIZE_CLOG       (5),
    .ISSUE_WIDTH_MAX     (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .br_req_id        (br_req_id),
    .rob_is_ptr       (rob_is_ptr),
    .ckpt_wr_en       (ckpt_wr_en),
    .ckpt_wr_idx      (ckpt_wr_idx),
    .rename_stall     (rename_stall),
    .br_mispredict    (br_mispredict),
    .br_resolve_robid (br_resolve_robid),
    .br_ret           (br_ret),
    .rob_flush_done   (rob_flush_done),
    .restore_en       (restore_en),
    .restore_idx      (restore_idx),
    .flush_fe         (flush_fe),
    .ckpt_free_cnt    (ckpt_free_cnt),
    .err_sticky       (err_sticky)
  );

  typedef struct {
    string      name;
    logic [1:0] req;
    logic [4:0] ptr;
    logic [1:0] ret;
    logic       mis;
    logic [4:0] mid;
    logic       done;
    logic [1:0] x_en;
    logic [1:0] x_idx0;
    logic [1:0] x_idx1;
    logic       x_stall;
    logic [2:0] x_free;
    logic       x_ren;
    logic [1:0] x_ridx;
    logic       x_flush;
    logic       x_err;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] free;
    logic       ren;
    logic [1:0] ridx;
    logic       flush;
    logic       err;
  } post_t;

  vec_t  tbl[$];
  post_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [1:0] req, input logic [4:0] ptr,
                              input logic [1:0] ret, input logic mis, input logic [4:0] mid,
                              input logic done, input logic [1:0] x_en, input logic [1:0] x_idx0,
                              input logic [1:0] x_idx1, input logic x_stall, input logic [2:0] x_free,
                              input logic x_ren, input logic [1:0] x_ridx, input logic x_flush,
                              input logic x_err);
    vec_t v;
    v.name = name; v.req = req; v.ptr = ptr; v.ret = ret; v.mis = mis; v.mid = mid;
    v.done = done; v.x_en = x_en; v.x_idx0 = x_idx0; v.x_idx1 = x_idx1;
    v.x_stall = x_stall; v.x_free = x_free; v.x_ren = x_ren; v.x_ridx = x_ridx;
    v.x_flush = x_flush; v.x_err = x_err;
    return v;
  endfunction

  task automatic drive_idle();
    br_req_id = '0; rob_is_ptr = '0; br_ret = '0;
    br_mispredict = 1'b0; br_resolve_robid = '0; rob_flush_done = 1'b0;
  endtask

  // Entered at posedge+1; leaves at the next posedge+1 after checking registered results.
  task automatic step(input vec_t v);
    post_t p;
    br_req_id = v.req; rob_is_ptr = v.ptr; br_ret = v.ret;
    br_mispredict = v.mis; br_resolve_robid = v.mid; rob_flush_done = v.done;
    #2;
    chk({v.name, ".wr_en"}, 32'(ckpt_wr_en), 32'(v.x_en));
    if (v.x_en[0]) chk({v.name, ".wr_idx0"}, 32'(ckpt_wr_idx[1:0]), 32'(v.x_idx0));
    if (v.x_en[1]) chk({v.name, ".wr_idx1"}, 32'(ckpt_wr_idx[3:2]), 32'(v.x_idx1));
    chk({v.name, ".stall"}, 32'(rename_stall), 32'(v.x_stall));
    p.name = v.name; p.free = v.x_free; p.ren = v.x_ren;
    p.ridx = v.x_ridx; p.flush = v.x_flush; p.err = v.x_err;
    sb.push_back(p);
    @(posedge clk);
    #1;
    drive_idle();
    p = sb.pop_front();
    chk({p.name, ".free"},     32'(ckpt_free_cnt), 32'(p.free));
    chk({p.name, ".rest_en"},  32'(restore_en),    32'(p.ren));
    chk({p.name, ".rest_idx"}, 32'(restore_idx),   32'(p.ridx));
    chk({p.name, ".flush"},    32'(flush_fe),      32'(p.flush));
    chk({p.name, ".err"},      32'(err_sticky),    32'(p.err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.free",     32'(ckpt_free_cnt), 32'd4);
    chk("reset.rest_en",  32'(restore_en),    32'd0);
    chk("reset.flush",    32'(flush_fe),      32'd0);
    chk("reset.err",      32'(err_sticky),    32'd0);
    chk("reset.stall",    32'(rename_stall),  32'd0);
    rst = 1'b1;

    //             name               req    ptr  ret   mis mid  dn  en     i0     i1   stl free  ren ridx  fl  err
    tbl.push_back(mk("alloc2",        2'b11, 5'd7, 2'b00, 0, 5'd0, 0, 2'b11, 2'd0, 2'd1, 0, 3'd2, 0, 2'd0, 0, 0));
    tbl.push_back(mk("alloc_slot1",   2'b10, 5'd12,2'b00, 0, 5'd0, 0, 2'b10, 2'd0, 2'd2, 0, 3'd1, 0, 2'd0, 0, 0));
    tbl.push_back(mk("stall_pair",    2'b11, 5'd20,2'b00, 0, 5'd0, 0, 2'b00, 2'd0, 2'd0, 1, 3'd1, 0, 2'd0, 0, 0));
    tbl.push_back(mk("alloc_last",    2'b01, 5'd30,2'b00, 0, 5'd0, 0, 2'b01, 2'd3, 2'd0, 0, 3'd0, 0, 2'd0, 0, 0));
    tbl.push_back(mk("full_ret",      2'b01, 5'd2, 2'b01, 0, 5'd0, 0, 2'b00, 2'd0, 2'd0, 1, 3'd1, 0, 2'd0, 0, 0));
    tbl.push_back(mk("wrap_alloc",    2'b01, 5'd2, 2'b00, 0, 5'd0, 0, 2'b01, 2'd0, 2'd0, 0, 3'd0, 0, 2'd0, 0, 0));
    tbl.push_back(mk("mis13_ret",     2'b01, 5'd0, 2'b01, 1, 5'd13,0, 2'b00, 2'd0, 2'd0, 1, 3'd4, 1, 2'd2, 1, 0));
    tbl.push_back(mk("restore",       2'b01, 5'd0, 2'b00, 0, 5'd0, 0, 2'b00, 2'd0, 2'd0, 1, 3'd4, 0, 2'd2, 1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk("drain_hold",  2'b01, 5'd0, 2'b00, 0, 5'd0, 0, 2'b00, 2'd0, 2'd0, 1, 3'd4, 0, 2'd2, 1, 0));
    tbl.push_back(mk("drain_done",    2'b00, 5'd0, 2'b00, 0, 5'd0, 1, 2'b00, 2'd0, 2'd0, 1, 3'd4, 0, 2'd2, 0, 0));
    tbl.push_back(mk("idle_alloc2",   2'b11, 5'd4, 2'b00, 0, 5'd0, 0, 2'b11, 2'd2, 2'd3, 0, 3'd2, 0, 2'd2, 0, 0));
    tbl.push_back(mk("mis_prio",      2'b01, 5'd9, 2'b00, 1, 5'd5, 0, 2'b00, 2'd0, 2'd0, 0, 3'd3, 1, 2'd3, 1, 0));
    tbl.push_back(mk("restore_ign",   2'b00, 5'd0, 2'b00, 1, 5'd4, 1, 2'b00, 2'd0, 2'd0, 1, 3'd3, 0, 2'd3, 1, 0));
    tbl.push_back(mk("drain_done2",   2'b00, 5'd0, 2'b00, 0, 5'd0, 1, 2'b00, 2'd0, 2'd0, 1, 3'd3, 0, 2'd3, 0, 0));
    tbl.push_back(mk("mis_miss",      2'b00, 5'd0, 2'b00, 1, 5'd20,0, 2'b00, 2'd0, 2'd0, 0, 3'd3, 0, 2'd3, 0, 1));
    tbl.push_back(mk("ptr_kept",      2'b01, 5'd14,2'b00, 0, 5'd0, 0, 2'b01, 2'd3, 2'd0, 0, 3'd2, 0, 2'd3, 0, 1));
    tbl.push_back(mk("ret1",          2'b00, 5'd0, 2'b01, 0, 5'd0, 0, 2'b00, 2'd0, 2'd0, 0, 3'd3, 0, 2'd3, 0, 1));
    tbl.push_back(mk("over_ret",      2'b00, 5'd0, 2'b11, 0, 5'd0, 0, 2'b00, 2'd0, 2'd0, 0, 3'd4, 0, 2'd3, 0, 1));
    tbl.push_back(mk("alloc_robwrap", 2'b11, 5'd31,2'b00, 0, 5'd0, 0, 2'b11, 2'd0, 2'd1, 0, 3'd2, 0, 2'd3, 0, 1));
    tbl.push_back(mk("mis_robid0",    2'b00, 5'd0, 2'b00, 1, 5'd0, 0, 2'b00, 2'd0, 2'd0, 0, 3'd3, 1, 2'd1, 1, 1));
    tbl.push_back(mk("restore3",      2'b00, 5'd0, 2'b00, 0, 5'd0, 0, 2'b00, 2'd0, 2'd0, 1, 3'd3, 0, 2'd1, 1, 1));
    tbl.push_back(mk("drain_done3",   2'b00, 5'd0, 2'b00, 0, 5'd0, 1, 2'b00, 2'd0, 2'd0, 1, 3'd3, 0, 2'd1, 0, 1));
    tbl.push_back(mk("mis_head",      2'b00, 5'd0, 2'b00, 1, 5'd31,0, 2'b00, 2'd0, 2'd0, 0, 3'd4, 1, 2'd0, 1, 1));
    tbl.push_back(mk("restore4",      2'b00, 5'd0, 2'b00, 0, 5'd0, 0, 2'b00, 2'd0, 2'd0, 1, 3'd4, 0, 2'd0, 1, 1));
    tbl.push_back(mk("drain_wait",    2'b00, 5'd0, 2'b00, 0, 5'd0, 0, 2'b00, 2'd0, 2'd0, 1, 3'd4, 0, 2'd0, 1, 1));

    foreach (tbl[i]) step(tbl[i]);

    // Asynchronous reset while draining: outputs clear before any clock edge.
    #2;
    rst = 1'b0;
    #1;
    chk("rst_drain.rest_en", 32'(restore_en),    32'd0);
    chk("rst_drain.rest_idx",32'(restore_idx),   32'd0);
    chk("rst_drain.flush",   32'(flush_fe),      32'd0);
    chk("rst_drain.err",     32'(err_sticky),    32'd0);
    chk("rst_drain.free",    32'(ckpt_free_cnt), 32'd4);
    chk("rst_drain.stall",   32'(rename_stall),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(mk("post_rst_alloc", 2'b01, 5'd1, 2'b00, 0, 5'd0, 0, 2'b01, 2'd0, 2'd0, 0, 3'd3, 0, 2'd0, 0, 0));
    step(mk("post_rst_overret",2'b00,5'd0, 2'b11, 0, 5'd0, 0, 2'b00, 2'd0, 2'd0, 0, 3'd4, 0, 2'd0, 0, 1));

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bratcr_ctrl.md
BRATCR_CTRL -- requirements
Module: bratcr_ctrl

Interface
REQ-001 Parameters: BRATCR_NUM_ETY, 4, checkpoint count (power of 2, >= 2); BRATCR_NUM_ETY_CLOG, 2, log2 of BRATCR_NUM_ETY; ROB_SIZE_CLOG, 5, ROB id width; ISSUE_WIDTH_MAX, 2, rename slots.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 br_req_id  in  ISSUE_WIDTH_MAX  slot i holds a valid branch needing a checkpoint; slot 0 is older.
REQ-005 rob_is_ptr  in  ROB_SIZE_CLOG  ROB id of slot 0; slot 1 id = rob_is_ptr+1, modulo 2^ROB_SIZE_CLOG.
REQ-006 ckpt_wr_en  out  ISSUE_WIDTH_MAX  per-slot checkpoint write strobe to BRATCR storage.
REQ-007 ckpt_wr_idx  out  ISSUE_WIDTH_MAX x BRATCR_NUM_ETY_CLOG  entry index per slot.
REQ-008 rename_stall  out  1  rename must hold the current group.
REQ-009 br_mispredict  in  1  one-cycle pulse, branch resolved mispredicted.
REQ-010 br_resolve_robid  in  ROB_SIZE_CLOG  ROB id of the mispredicted branch.
REQ-011 br_ret  in  ISSUE_WIDTH_MAX  per-lane branch retire strobe (lanes in order).
REQ-012 rob_flush_done  in  1  ROB/front end finished squash.
REQ-013 restore_en  out  1  registered; copy checkpoint restore_idx into RAT.
REQ-014 restore_idx  out  BRATCR_NUM_ETY_CLOG  registered; entry to restore.
REQ-015 flush_fe  out  1  registered; squash younger front-end/ROB state.
REQ-016 ckpt_free_cnt  out  BRATCR_NUM_ETY_CLOG+1  free entries, 0..BRATCR_NUM_ETY.
REQ-017 err_sticky  out  1  protocol error seen; cleared only by reset.

Function
REQ-018 Entries form a circular FIFO: head (oldest), tail (next alloc), each BRATCR_NUM_ETY_CLOG bits, wrap modulo BRATCR_NUM_ETY; per-entry valid bit and stored robid.
REQ-019 States: IDLE, RESTORE, DRAIN.
REQ-020 rename_stall = (state != IDLE) | (ckpt_free_cnt < popcount(br_req_id)); combinational.
REQ-021 In IDLE with no stall, each set br_req_id[i] allocates in slot order: slot 0 gets tail, slot 1 gets tail+1 if both set, else tail; ckpt_wr_en/idx combinational in the same cycle; valid and robid written at the edge; tail advances by popcount.
REQ-022 When stalled, ckpt_wr_en = 0 and no allocation occurs (no partial allocation of a two-branch group).
REQ-023 br_ret frees popcount(br_ret) entries from head, every cycle in every state; head advances, valid cleared.
REQ-024 A retire count exceeding occupancy frees only the occupied entries and sets err_sticky.
REQ-025 Allocation and retire in the same cycle are both applied; ckpt_free_cnt = old + freed - allocated.
REQ-026 In IDLE, br_mispredict CAM-matches br_resolve_robid against valid entries; on hit at index k: restore_idx <= k, tail <= k, entries k..old tail-1 invalidated, next state RESTORE.
REQ-027 Mispredict with no hit sets err_sticky and stays IDLE; mispredict outside IDLE is ignored.
REQ-028 Mispredict has priority over same-cycle allocation: no allocation that cycle.
REQ-029 Retire in the mispredict cycle is applied to head; if it frees entry k, restore still uses k (data unchanged until reallocated).
REQ-030 RESTORE lasts exactly one cycle: restore_en = 1, flush_fe = 1; next state DRAIN.
REQ-031 DRAIN: flush_fe held 1 until rob_flush_done sampled 1, then IDLE with flush_fe = 0 on the following cycle.
REQ-032 rob_flush_done outside DRAIN is ignored.

Reset
REQ-033 On rst low, asynchronously: state IDLE, head = tail = 0, all valid = 0, ckpt_free_cnt = BRATCR_NUM_ETY, restore_en = 0, restore_idx = 0, flush_fe = 0, err_sticky = 0.
REQ-034 Reset asserted in RESTORE or DRAIN aborts recovery; after release the block is in IDLE and accepts requests on the first rising edge.

Verification
REQ-035 Reset, br_req_id=11, rob_is_ptr=7 -> ckpt_wr_idx {0,1}, robids 7,8, free 4->2, no stall.
REQ-036 Fill 4 entries, then br_req_id=01 -> rename_stall=1, ckpt_wr_en=00; same cycle br_ret=01 -> next cycle free=1, request accepted at idx 0 (wrap).
REQ-037 Entries robid 3,5,9 at idx 0..2; mispredict robid 5 -> next cycle restore_en=1, restore_idx=1, flush_fe=1; free=3 (head 0, tail 1); stall until DRAIN exits.
REQ-038 In DRAIN, hold rob_flush_done=0 5 cycles -> flush_fe and stall stay 1; pulse done -> IDLE, flush_fe=0 next cycle.
REQ-039 Mispredict robid 20 not present -> err_sticky=1, state IDLE, pointers unchanged; br_ret=11 with one entry -> free=4, err_sticky remains 1.
REQ-040 Assert rst in DRAIN -> all outputs at reset values immediately; after release br_req_id=01 allocates idx 0.
